// File: rtl/bomb_drop_ctrl.sv
// Bomb placement and fuse controller: snaps the player centre to the tile grid on a
// drop-key edge, runs a frame-counted fuse, then a frame-counted blast window.
module bomb_drop_ctrl #(
   parameter int GRID_X0      = 0,
   parameter int GRID_Y0      = 96,
   parameter int TILE_LOG2    = 5,
   parameter int GRID_COLS    = 20,
   parameter int GRID_ROWS    = 12,
   parameter int PLAYER_SIZE  = 64,
   parameter int FUSE_FRAMES  = 90,
   parameter int BLAST_FRAMES = 15
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic signed [10:0] topLeftX,
   input  logic signed [10:0] topLeftY,
   input  logic               dropKey,
   input  logic               chainTrigger,
   output logic               bombActive,
   output logic               explodeActive,
   output logic               explodePulse,
   output logic signed [10:0] bombTopLeftX,
   output logic signed [10:0] bombTopLeftY,
   output logic [4:0]         bombCol,
   output logic [3:0]         bombRow
);

   // state      | meaning
   // IDLE_ST    | no bomb on the field
   // ARMED_ST   | bomb placed, fuse counting frames
   // EXPLODE_ST | blast window counting frames
   localparam logic [1:0] IDLE_ST    = 2'd0;
   localparam logic [1:0] ARMED_ST   = 2'd1;
   localparam logic [1:0] EXPLODE_ST = 2'd2;

   localparam int MAX_FRAMES = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

   localparam logic signed [11:0] OFF_X   = 12'(PLAYER_SIZE / 2 - GRID_X0);
   localparam logic signed [11:0] OFF_Y   = 12'(PLAYER_SIZE / 2 - GRID_Y0);
   localparam logic signed [11:0] COL_MAX = 12'(GRID_COLS - 1);
   localparam logic signed [11:0] ROW_MAX = 12'(GRID_ROWS - 1);
   localparam logic [10:0]        X0     = 11'(GRID_X0);
   localparam logic [10:0]        Y0     = 11'(GRID_Y0);

   logic [1:0]         state;
   logic [CNT_W-1:0]   frame_cnt;
   logic               drop_key_d;
   logic               drop;
   logic               frame_last;

   logic signed [11:0] cx, cy;
   logic signed [11:0] col_raw, row_raw;
   logic [4:0]         snap_col;
   logic [3:0]         snap_row;
   logic [10:0]        snap_x, snap_y;

   assign drop       = dropKey & ~drop_key_d;
   assign frame_last = startOfFrame && (frame_cnt == CNT_W'(1));

   // Snap the sprite centre to a tile, clamping anything off the playfield to the edge tile.
   always_comb begin
      cx      = $signed({topLeftX[10], topLeftX}) + OFF_X;
      cy      = $signed({topLeftY[10], topLeftY}) + OFF_Y;
      col_raw = cx >>> TILE_LOG2;
      row_raw = cy >>> TILE_LOG2;
      if (col_raw[11])
         snap_col = 5'd0;
      else if (col_raw > COL_MAX)
         snap_col = COL_MAX[4:0];
      else
         snap_col = col_raw[4:0];
      if (row_raw[11])
         snap_row = 4'd0;
      else if (row_raw > ROW_MAX)
         snap_row = ROW_MAX[3:0];
      else
         snap_row = row_raw[3:0];
      snap_x = X0 + (11'(snap_col) << TILE_LOG2);
      snap_y = Y0 + (11'(snap_row) << TILE_LOG2);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE_ST;
         frame_cnt    <= '0;
         drop_key_d   <= 1'b1;
         explodePulse <= 1'b0;
         bombTopLeftX <= '0;
         bombTopLeftY <= '0;
         bombCol      <= '0;
         bombRow      <= '0;
      end else begin
         drop_key_d   <= dropKey;
         explodePulse <= 1'b0;
         case (state)
            IDLE_ST: begin
               if (drop) begin
                  state        <= ARMED_ST;
                  frame_cnt    <= CNT_W'(FUSE_FRAMES);
                  bombCol      <= snap_col;
                  bombRow      <= snap_row;
                  bombTopLeftX <= $signed(snap_x);
                  bombTopLeftY <= $signed(snap_y);
               end
            end
            ARMED_ST: begin
               // Chain and natural expiry share one branch, so they yield a single pulse.
               if (chainTrigger || frame_last) begin
                  state        <= EXPLODE_ST;
                  frame_cnt    <= CNT_W'(BLAST_FRAMES);
                  explodePulse <= 1'b1;
               end else if (startOfFrame) begin
                  frame_cnt <= frame_cnt - CNT_W'(1);
               end
            end
            EXPLODE_ST: begin
               if (frame_last) begin
                  state     <= IDLE_ST;
                  frame_cnt <= '0;
               end else if (startOfFrame) begin
                  frame_cnt <= frame_cnt - CNT_W'(1);
               end
            end
            default: begin
               state     <= IDLE_ST;
               frame_cnt <= '0;
            end
         endcase
      end
   end

   assign bombActive    = (state == ARMED_ST);
   assign explodeActive = (state == EXPLODE_ST);

endmodule

// File: tb/tb_bomb_drop_ctrl.sv
// Directed bench for bomb_drop_ctrl with a short fuse (3 frames) and blast (2 frames).
module tb_bomb_drop_ctrl;

   logic               clk = 1'b0;
   logic               resetN;
   logic               startOfFrame;
   logic signed [10:0] topLeftX, topLeftY;
   logic               dropKey;
   logic               chainTrigger;
   logic               bombActive, explodeActive, explodePulse;
   logic signed [10:0] bombTopLeftX, bombTopLeftY;
   logic [4:0]         bombCol;
   logic [3:0]         bombRow;

   int n_total = 0;
   int n_pass  = 0;
   int n_pulse = 0;
   int pulse_base;

   bomb_drop_ctrl #(.FUSE_FRAMES(3), .BLAST_FRAMES(2)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .topLeftX(topLeftX), .topLeftY(topLeftY), .dropKey(dropKey),
      .chainTrigger(chainTrigger), .bombActive(bombActive),
      .explodeActive(explodeActive), .explodePulse(explodePulse),
      .bombTopLeftX(bombTopLeftX), .bombTopLeftY(bombTopLeftY),
      .bombCol(bombCol), .bombRow(bombRow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (explodePulse === 1'b1) n_pulse++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      repeat (9) tick();
   endtask

   task automatic press(input int x, input int y);
      topLeftX = 11'(x);
      topLeftY = 11'(y);
      dropKey  = 1'b0;
      tick();
      dropKey  = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      tick();
   endtask

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; chainTrigger = 1'b0;
      dropKey = 1'b1; topLeftX = 11'sd280; topLeftY = 11'sd185;
      #1;
      check("reset_bomb", bombActive, 0);
      check("reset_expl", explodeActive, 0);
      check("reset_pulse", explodePulse, 0);
      check("reset_x", bombTopLeftX, 0);
      repeat (3) tick();
      resetN = 1'b1;
      repeat (4) tick();
      check("held_key_no_drop", bombActive, 0);

      // Press at (280,185): col 9 row 3, bomb at (288,192)
      press(280, 185);
      check("drop_armed", bombActive, 1);
      check("drop_col", bombCol, 9);
      check("drop_row", bombRow, 3);
      check("drop_x", bombTopLeftX, 288);
      check("drop_y", bombTopLeftY, 192);
      topLeftX = 11'sd400; topLeftY = 11'sd300;
      tick();
      check("moved_x", bombTopLeftX, 288);
      check("moved_col", bombCol, 9);

      // Fuse of 3 frames; a press during armed is ignored
      pulse_base = n_pulse;
      frame();
      dropKey = 1'b0; tick(); dropKey = 1'b1; tick();
      check("armed_press_x", bombTopLeftX, 288);
      frame();
      check("before_expiry", bombActive, 1);
      check("no_early_pulse", explodePulse, 0);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("expiry_pulse", explodePulse, 1);
      check("expiry_expl", explodeActive, 1);
      check("expiry_bomb_off", bombActive, 0);
      tick();
      check("pulse_one_cycle", explodePulse, 0);
      repeat (8) tick();
      dropKey = 1'b0; tick(); dropKey = 1'b1; tick();
      frame();
      check("blast_frame1", explodeActive, 1);
      check("blast_no_rearm", bombActive, 0);
      frame();
      check("blast_done", explodeActive, 0);
      check("held_across_idle", bombActive, 0);
      check("single_pulse", n_pulse - pulse_base, 1);
      check("latched_after_blast_y", bombTopLeftY, 192);

      // Clamp cases
      do_reset();
      press(620, 185);
      check("clamp_col_hi", bombCol, 19);
      check("clamp_x_hi", bombTopLeftX, 608);
      do_reset();
      press(280, 60);
      check("clamp_row_lo", bombRow, 0);
      check("clamp_y_lo", bombTopLeftY, 96);
      do_reset();
      press(-40, 460);
      check("clamp_col_lo", bombCol, 0);
      check("clamp_x_lo", bombTopLeftX, 0);
      check("clamp_row_hi", bombRow, 11);
      check("clamp_y_hi", bombTopLeftY, 448);

      // Chain trigger coinciding with fuse expiry
      do_reset();
      press(100, 200);
      pulse_base = n_pulse;
      frame();
      frame();
      startOfFrame = 1'b1; chainTrigger = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("chain_expiry_pulse", explodePulse, 1);
      tick();
      chainTrigger = 1'b0;
      check("chain_ignored_in_blast", explodePulse, 0);
      frame();
      frame();
      check("chain_expiry_idle", explodeActive, 0);
      check("chain_expiry_once", n_pulse - pulse_base, 1);

      // Chain trigger mid-fuse
      press(100, 200);
      frame();
      chainTrigger = 1'b1;
      tick();
      chainTrigger = 1'b0;
      check("chain_mid_pulse", explodePulse, 1);
      check("chain_mid_expl", explodeActive, 1);
      frame();
      frame();

      // Reset during armed
      press(280, 185);
      frame();
      pulse_base = n_pulse;
      resetN = 1'b0;
      #1;
      check("rst_armed_bomb", bombActive, 0);
      check("rst_armed_col", bombCol, 0);
      check("rst_armed_x", bombTopLeftX, 0);
      tick(); tick();
      resetN = 1'b1;
      tick();
      check("rst_armed_no_pulse", n_pulse - pulse_base, 0);
      press(280, 185);
      check("rearm_after_rst", bombActive, 1);
      check("rearm_col", bombCol, 9);

      // Reset during explode
      chainTrigger = 1'b1;
      tick();
      chainTrigger = 1'b0;
      tick();
      check("pre_rst_expl", explodeActive, 1);
      resetN = 1'b0;
      #1;
      check("rst_expl_active", explodeActive, 0);
      check("rst_expl_y", bombTopLeftY, 0);
      check("rst_expl_row", bombRow, 0);
      tick();
      resetN = 1'b1;
      tick();
      press(620, 460);
      check("rearm2_bomb", bombActive, 1);
      check("rearm2_row", bombRow, 11);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
